// File: rtl/vote_pkg.sv
// Shared types and sizes for the voting session controller and its decoder.
package vote_pkg;

   localparam int N_VOTERS = 3;
   localparam int CNT_W    = 2;
   localparam int ONEHOT_W = 5;
   localparam int WORD_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_SETTLE,
      S_SAMPLE,
      S_REPORT
   } vote_state_t;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Voter, counter and result signals of one voting session.
// slave: the session controller. master: whoever drives it (front-ends/bench).
interface vote_session_ctrl_if;
   import vote_pkg::*;

   logic                start_i;
   logic [N_VOTERS-1:0] vote_valid_i;
   logic [N_VOTERS-1:0] vote_yes_i;
   logic [N_VOTERS-1:0] vote_ack_o;
   logic                busy_o;
   logic [WORD_W-1:0]   tally_word_o;
   logic [ONEHOT_W-1:0] tally_onehot_i;
   logic                result_valid_o;
   logic                result_ready_i;
   logic [CNT_W-1:0]    yes_count_o;
   logic                majority_o;
   logic                timed_out_o;
   logic [N_VOTERS-1:0] abstain_o;
   logic                tally_err_o;

   modport slave (
      input  start_i, vote_valid_i, vote_yes_i, tally_onehot_i, result_ready_i,
      output vote_ack_o, busy_o, tally_word_o, result_valid_o, yes_count_o,
             majority_o, timed_out_o, abstain_o, tally_err_o
   );

   modport master (
      output start_i, vote_valid_i, vote_yes_i, tally_onehot_i, result_ready_i,
      input  vote_ack_o, busy_o, tally_word_o, result_valid_o, yes_count_o,
             majority_o, timed_out_o, abstain_o, tally_err_o
   );

endinterface

// File: rtl/vote_tally_decode.sv
// Turns the vote counter's one-hot tally into a binary yes-count.
// Anything other than exactly one of bits 0..3 is flagged and reads as 0.
module vote_tally_decode
   import vote_pkg::*;
(
   input  logic [ONEHOT_W-1:0] onehot_i,
   output logic [CNT_W-1:0]    count_o,
   output logic                err_o
);

   // One-hot to binary; bit4 (four yes votes) cannot occur with three voters.
   always_comb begin
      count_o = '0;
      err_o   = 1'b0;
      case (onehot_i)
         5'b00001: count_o = 2'd0;
         5'b00010: count_o = 2'd1;
         5'b00100: count_o = 2'd2;
         5'b01000: count_o = 2'd3;
         default:  err_o   = 1'b1;
      endcase
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Runs one three-voter ballot: collect with timeout, let the external counter
// settle on the latched ballot word, sample its tally, hold the result until taken.
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TMR_W          = 8
)(
   input  logic               clk,
   input  logic               rst,
   vote_session_ctrl_if.slave bus
);

   localparam logic [TMR_W-1:0]    TMR_INIT  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [N_VOTERS-1:0] ALL_VOTED = '1;

   vote_state_t         state_q, state_d;
   logic [N_VOTERS-1:0] ballot_q, ballot_d;
   logic [N_VOTERS-1:0] voted_q, voted_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [N_VOTERS-1:0] ack_q, ack_d;
   logic                timed_out_q, timed_out_d;
   logic [N_VOTERS-1:0] abstain_q, abstain_d;
   logic [CNT_W-1:0]    yes_count_q, yes_count_d;
   logic                majority_q, majority_d;
   logic                tally_err_q, tally_err_d;

   logic [N_VOTERS-1:0] accept;
   logic [N_VOTERS-1:0] voted_nxt;
   logic [CNT_W-1:0]    dec_count;
   logic                dec_err;

   vote_tally_decode u_decode (
      .onehot_i (bus.tally_onehot_i),
      .count_o  (dec_count),
      .err_o    (dec_err)
   );

   // Next-state and datapath updates for the session sequence.
   always_comb begin
      state_d     = state_q;
      ballot_d    = ballot_q;
      voted_d     = voted_q;
      timer_d     = timer_q;
      ack_d       = '0;
      timed_out_d = timed_out_q;
      abstain_d   = abstain_q;
      yes_count_d = yes_count_q;
      majority_d  = majority_q;
      tally_err_d = tally_err_q;
      accept      = '0;
      voted_nxt   = voted_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d     = S_COLLECT;
               ballot_d    = '0;
               voted_d     = '0;
               timer_d     = TMR_INIT;
               timed_out_d = 1'b0;
               abstain_d   = '0;
               yes_count_d = '0;
               majority_d  = 1'b0;
               tally_err_d = 1'b0;
            end
         end

         S_COLLECT: begin
            // First strobe per voter wins; repeats are dropped silently.
            accept    = bus.vote_valid_i & ~voted_q;
            voted_nxt = voted_q | accept;
            ballot_d  = (ballot_q & ~accept) | (bus.vote_yes_i & accept);
            voted_d   = voted_nxt;
            ack_d     = accept;
            if (voted_nxt == ALL_VOTED || timer_q == '0) begin
               // A ballot landing on the last timer cycle still counts, so
               // the exit decision uses the post-update mask.
               state_d     = S_SETTLE;
               abstain_d   = ~voted_nxt;
               timed_out_d = (voted_nxt != ALL_VOTED);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         // The counter has had a cycle on the final ballot word; one more
         // before sampling keeps its path off the critical edge.
         S_SETTLE: state_d = S_SAMPLE;

         S_SAMPLE: begin
            yes_count_d = dec_count;
            majority_d  = (dec_count >= 2'd2);
            tally_err_d = dec_err;
            state_d     = S_REPORT;
         end

         S_REPORT: begin
            if (bus.result_ready_i) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers; reset abandons any session in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ballot_q    <= '0;
         voted_q     <= '0;
         timer_q     <= '0;
         ack_q       <= '0;
         timed_out_q <= 1'b0;
         abstain_q   <= '0;
         yes_count_q <= '0;
         majority_q  <= 1'b0;
         tally_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ballot_q    <= ballot_d;
         voted_q     <= voted_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         timed_out_q <= timed_out_d;
         abstain_q   <= abstain_d;
         yes_count_q <= yes_count_d;
         majority_q  <= majority_d;
         tally_err_q <= tally_err_d;
      end
   end

   assign bus.vote_ack_o     = ack_q;
   assign bus.busy_o         = (state_q != S_IDLE);
   assign bus.tally_word_o   = {1'b0, ballot_q};
   assign bus.result_valid_o = (state_q == S_REPORT);
   assign bus.yes_count_o    = yes_count_q;
   assign bus.majority_o     = majority_q;
   assign bus.timed_out_o    = timed_out_q;
   assign bus.abstain_o      = abstain_q;
   assign bus.tally_err_o    = tally_err_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl with a behavioural vote counter and a
// result scoreboard (expected results queued when ballots are driven).
module tb_vote_session_ctrl;
   import vote_pkg::*;

   typedef struct packed {
      logic [1:0] cnt;
      logic       maj;
      logic       to;
      logic [2:0] ab;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   logic       force_en  = 1'b0;
   logic [4:0] force_val = '0;
   logic [4:0] model_onehot;

   vote_session_ctrl_if bus();

   vote_session_ctrl #(.TIMEOUT_CYCLES(4), .TMR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Stand-in for the vote counter: one-hot of the number of ones in the word.
   always_comb model_onehot = 5'd1 << $countones(bus.tally_word_o);
   assign bus.tally_onehot_i = force_en ? force_val : model_onehot;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] cnt, input logic maj, input logic to,
                               input logic [2:0] ab, input logic err);
      exp_t e;
      e.cnt = cnt; e.maj = maj; e.to = to; e.ab = ab; e.err = err;
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  8'(bus.busy_o), 8'd0);
      check({tag, "_ack"},   8'(bus.vote_ack_o), 8'd0);
      check({tag, "_valid"}, 8'(bus.result_valid_o), 8'd0);
      check({tag, "_word"},  8'(bus.tally_word_o), 8'd0);
      check({tag, "_cnt"},   8'(bus.yes_count_o), 8'd0);
      check({tag, "_maj"},   8'(bus.majority_o), 8'd0);
      check({tag, "_to"},    8'(bus.timed_out_o), 8'd0);
      check({tag, "_ab"},    8'(bus.abstain_o), 8'd0);
      check({tag, "_err"},   8'(bus.tally_err_o), 8'd0);
   endtask

   // Waits (bounded) for a result, compares it with the oldest expectation,
   // then completes the handshake and checks the controller went idle.
   task automatic wait_result(input string tag, input int budget);
      exp_t e;
      int   n = 0;
      while (!bus.result_valid_o && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 8'(bus.result_valid_o), 8'd1);
      check({tag, "_sb_size"}, 8'(sb_q.size()), 8'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (bus.result_valid_o) begin
            check({tag, "_cnt"}, 8'(bus.yes_count_o), 8'(e.cnt));
            check({tag, "_maj"}, 8'(bus.majority_o),  8'(e.maj));
            check({tag, "_to"},  8'(bus.timed_out_o), 8'(e.to));
            check({tag, "_ab"},  8'(bus.abstain_o),   8'(e.ab));
            check({tag, "_err"}, 8'(bus.tally_err_o), 8'(e.err));
         end
      end
      bus.result_ready_i = 1'b1;
      tick();
      bus.result_ready_i = 1'b0;
      check({tag, "_valid_drop"}, 8'(bus.result_valid_o), 8'd0);
      check({tag, "_idle"}, 8'(bus.busy_o), 8'd0);
   endtask

   // All three voters strobe in the first COLLECT cycle.
   task automatic fast_session(input string tag, input logic [2:0] yes, input exp_t e);
      bus.start_i = 1'b1;
      tick();
      bus.start_i      = 1'b0;
      bus.vote_valid_i = 3'b111;
      bus.vote_yes_i   = yes;
      sb_q.push_back(e);
      check({tag, "_busy"}, 8'(bus.busy_o), 8'd1);
      tick();
      bus.vote_valid_i = 3'b000;
      check({tag, "_ack"},  8'(bus.vote_ack_o), 8'h07);
      check({tag, "_word"}, 8'(bus.tally_word_o), 8'({1'b0, yes}));
      tick();
      check({tag, "_ack_once"}, 8'(bus.vote_ack_o), 8'd0);
      check({tag, "_early"}, 8'(bus.result_valid_o), 8'd0);
      tick();
      check({tag, "_latency"}, 8'(bus.result_valid_o), 8'd1);
      wait_result(tag, 4);
   endtask

   initial begin
      bus.start_i        = 1'b0;
      bus.vote_valid_i   = '0;
      bus.vote_yes_i     = '0;
      bus.result_ready_i = 1'b0;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Full vote, fast path
      fast_session("fast", 3'b101, mk(2'd2, 1'b1, 1'b0, 3'b000, 1'b0));

      // Timeout: only voter 1 votes yes, 4 COLLECT cycles
      bus.start_i = 1'b1;
      tick();
      bus.start_i      = 1'b0;
      bus.vote_valid_i = 3'b010;
      bus.vote_yes_i   = 3'b010;
      sb_q.push_back(mk(2'd1, 1'b0, 1'b1, 3'b101, 1'b0));
      tick();
      bus.vote_valid_i = 3'b000;
      check("to_ack", 8'(bus.vote_ack_o), 8'h02);
      tick();
      check("to_ack_once", 8'(bus.vote_ack_o), 8'd0);
      tick();
      tick();
      check("to_busy", 8'(bus.busy_o), 8'd1);
      tick();
      check("to_not_yet", 8'(bus.result_valid_o), 8'd0);
      tick();
      check("to_latency", 8'(bus.result_valid_o), 8'd1);
      wait_result("timeout", 4);

      // Duplicate strobe, strobe on the timer==0 cycle, strobes in REPORT
      bus.start_i = 1'b1;
      tick();
      bus.start_i      = 1'b0;
      bus.vote_valid_i = 3'b001;
      bus.vote_yes_i   = 3'b001;
      sb_q.push_back(mk(2'd2, 1'b1, 1'b1, 3'b010, 1'b0));
      tick();
      check("dup_ack_first", 8'(bus.vote_ack_o), 8'h01);
      tick();
      check("dup_ack_none", 8'(bus.vote_ack_o), 8'd0);
      bus.vote_valid_i = 3'b000;
      tick();
      bus.vote_valid_i = 3'b100;
      bus.vote_yes_i   = 3'b100;
      tick();
      bus.vote_valid_i = 3'b000;
      check("late_ack", 8'(bus.vote_ack_o), 8'h04);
      check("late_word", 8'(bus.tally_word_o), 8'h05);
      tick();
      tick();
      check("bp_enter", 8'(bus.result_valid_o), 8'd1);

      // Backpressure: ready low for 10 cycles, strobes and start pulses ignored
      for (int i = 0; i < 10; i++) begin
         bus.vote_valid_i = 3'b010;
         bus.vote_yes_i   = 3'b010;
         bus.start_i      = i[0];
         tick();
         check("bp_valid", 8'(bus.result_valid_o), 8'd1);
         check("bp_ack",   8'(bus.vote_ack_o), 8'd0);
         check("bp_cnt",   8'(bus.yes_count_o), 8'd2);
         check("bp_maj",   8'(bus.majority_o), 8'd1);
         check("bp_to",    8'(bus.timed_out_o), 8'd1);
         check("bp_ab",    8'(bus.abstain_o), 8'h02);
         check("bp_word",  8'(bus.tally_word_o), 8'h05);
      end
      bus.vote_valid_i = 3'b000;
      bus.start_i      = 1'b0;
      wait_result("late", 2);

      // Illegal tallies, started back-to-back after the handshake
      force_en  = 1'b1;
      force_val = 5'b00110;
      fast_session("ill_two", 3'b111, mk(2'd0, 1'b0, 1'b0, 3'b000, 1'b1));
      force_val = 5'b10000;
      fast_session("ill_b4", 3'b011, mk(2'd0, 1'b0, 1'b0, 3'b000, 1'b1));
      force_val = 5'b00000;
      fast_session("ill_zero", 3'b111, mk(2'd0, 1'b0, 1'b0, 3'b000, 1'b1));
      force_val = 5'b01000;
      fast_session("dec_three", 3'b000, mk(2'd3, 1'b1, 1'b0, 3'b000, 1'b0));
      force_en = 1'b0;

      // Reset mid-session after one ballot
      bus.start_i = 1'b1;
      tick();
      bus.start_i      = 1'b0;
      bus.vote_valid_i = 3'b001;
      bus.vote_yes_i   = 3'b001;
      tick();
      bus.vote_valid_i = 3'b000;
      check("rst_pre_ack", 8'(bus.vote_ack_o), 8'h01);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      tick();
      rst = 1'b0;
      tick();
      check("rst_no_result", 8'(bus.result_valid_o), 8'd0);

      // Clean session after reset: voter 0 must show as an abstainer
      bus.start_i = 1'b1;
      tick();
      bus.start_i      = 1'b0;
      bus.vote_valid_i = 3'b110;
      bus.vote_yes_i   = 3'b110;
      sb_q.push_back(mk(2'd2, 1'b1, 1'b1, 3'b001, 1'b0));
      tick();
      bus.vote_valid_i = 3'b000;
      check("post_rst_ack", 8'(bus.vote_ack_o), 8'h06);
      wait_result("post_rst", 12);

      check("sb_drained", 8'(sb_q.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
